// File: rtl/pn_token_tx_if.sv
// Token/result channel between pn_token_tx (master) and the PN evaluator (slave).
interface pn_token_tx_if;
   logic [1:0]  pn_mode;
   logic        pn_operator;
   logic [2:0]  pn_in;
   logic        pn_in_valid;
   logic        pn_out_valid;
   logic [31:0] pn_out;

   modport master (
      output pn_mode, pn_operator, pn_in, pn_in_valid,
      input  pn_out_valid, pn_out
   );

   modport slave (
      input  pn_mode, pn_operator, pn_in, pn_in_valid,
      output pn_out_valid, pn_out
   );
endinterface

// File: rtl/pn_token_tx.sv
// Streams a host-loaded Polish Notation expression to the PN evaluator and
// collects its result burst, flagging illegal lengths and result timeouts.
module pn_token_tx #(
   parameter int MAX_TOK = 12,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          cfg_mode,
   input  logic [3:0]          cfg_len,
   input  logic [11:0]         cfg_op,
   input  logic [35:0]         cfg_val,
   output logic                busy,
   output logic                done,
   output logic                err_len,
   output logic                err_timeout,
   output logic [2:0]          res_cnt,
   output logic [127:0]        res_data,
   pn_token_tx_if.master       pn
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SEND,
      WAIT,
      FIN
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [3:0]        len_q, len_d;
   logic [11:0]       op_q, op_d;
   logic [35:0]       val_q, val_d;
   logic [3:0]        tok_idx_q, tok_idx_d;
   logic [2:0]        exp_q, exp_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [2:0]        res_cnt_q, res_cnt_d;
   logic [3:0][31:0]  res_q, res_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_len_q, err_len_d;
   logic              err_timeout_q, err_timeout_d;
   logic [1:0]        pn_mode_q, pn_mode_d;
   logic              pn_operator_q, pn_operator_d;
   logic [2:0]        pn_in_q, pn_in_d;
   logic              pn_in_valid_q, pn_in_valid_d;
   logic              len_bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         mode_q        <= '0;
         len_q         <= '0;
         op_q          <= '0;
         val_q         <= '0;
         tok_idx_q     <= '0;
         exp_q         <= '0;
         tmo_q         <= '0;
         res_cnt_q     <= '0;
         res_q         <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_len_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         pn_mode_q     <= '0;
         pn_operator_q <= 1'b0;
         pn_in_q       <= '0;
         pn_in_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         len_q         <= len_d;
         op_q          <= op_d;
         val_q         <= val_d;
         tok_idx_q     <= tok_idx_d;
         exp_q         <= exp_d;
         tmo_q         <= tmo_d;
         res_cnt_q     <= res_cnt_d;
         res_q         <= res_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_len_q     <= err_len_d;
         err_timeout_q <= err_timeout_d;
         pn_mode_q     <= pn_mode_d;
         pn_operator_q <= pn_operator_d;
         pn_in_q       <= pn_in_d;
         pn_in_valid_q <= pn_in_valid_d;
      end
   end

   // Sorted modes (0/1) carry one result per operator triple; stack modes yield one.
   assign len_bad = (len_q == 4'd0) || (len_q > 4'(MAX_TOK)) ||
                    (!mode_q[1] && ((len_q % 4'd3) != 4'd0));

   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      len_d         = len_q;
      op_d          = op_q;
      val_d         = val_q;
      tok_idx_d     = tok_idx_q;
      exp_d         = exp_q;
      tmo_d         = tmo_q;
      res_cnt_d     = res_cnt_q;
      res_d         = res_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      err_len_d     = err_len_q;
      err_timeout_d = err_timeout_q;
      pn_mode_d     = '0;
      pn_operator_d = 1'b0;
      pn_in_d       = '0;
      pn_in_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d        = cfg_mode;
               len_d         = cfg_len;
               op_d          = cfg_op;
               val_d         = cfg_val;
               tok_idx_d     = '0;
               tmo_d         = '0;
               res_cnt_d     = '0;
               res_d         = '0;
               err_len_d     = 1'b0;
               err_timeout_d = 1'b0;
               busy_d        = 1'b1;
               state_d       = CHECK;
            end
         end

         CHECK: begin
            exp_d = mode_q[1] ? 3'd1 : 3'(len_q / 4'd3);
            if (len_bad) begin
               err_len_d = 1'b1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = FIN;
            end else begin
               state_d = SEND;
            end
         end

         // The latched op/val vectors are consumed LSB-first by shifting.
         SEND: begin
            if (tok_idx_q != len_q) begin
               pn_in_valid_d = 1'b1;
               pn_operator_d = op_q[0];
               pn_in_d       = val_q[2:0];
               pn_mode_d     = (tok_idx_q == 4'd0) ? mode_q : 2'd0;
               op_d          = op_q >> 1;
               val_d         = val_q >> 3;
               tok_idx_d     = tok_idx_q + 4'd1;
            end else begin
               tmo_d   = '0;
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (res_cnt_q == exp_q) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = FIN;
            end else if (pn.pn_out_valid) begin
               res_d[res_cnt_q[1:0]] = pn.pn_out;
               res_cnt_d             = res_cnt_q + 3'd1;
               tmo_d                 = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_d == TW'(TIMEOUT)) begin
                  err_timeout_d = 1'b1;
                  busy_d        = 1'b0;
                  done_d        = 1'b1;
                  state_d       = FIN;
               end
            end
         end

         FIN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign err_len        = err_len_q;
   assign err_timeout    = err_timeout_q;
   assign res_cnt        = res_cnt_q;
   assign res_data       = res_q;
   assign pn.pn_mode     = pn_mode_q;
   assign pn.pn_operator = pn_operator_q;
   assign pn.pn_in       = pn_in_q;
   assign pn.pn_in_valid = pn_in_valid_q;

endmodule

// File: tb/tb_pn_token_tx.sv
// Directed bench for pn_token_tx: token streaming, result capture, length
// errors, timeouts, mid-stream reset and start handling around FIN.
module tb_pn_token_tx;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   cfg_mode = '0;
   logic [3:0]   cfg_len = '0;
   logic [11:0]  cfg_op = '0;
   logic [35:0]  cfg_val = '0;
   logic         busy, done, err_len, err_timeout;
   logic [2:0]   res_cnt;
   logic [127:0] res_data;
   int           check_cnt = 0;
   int           pass_cnt = 0;

   pn_token_tx_if pn ();

   pn_token_tx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cfg_mode    (cfg_mode),
      .cfg_len     (cfg_len),
      .cfg_op      (cfg_op),
      .cfg_val     (cfg_val),
      .busy        (busy),
      .done        (done),
      .err_len     (err_len),
      .err_timeout (err_timeout),
      .res_cnt     (res_cnt),
      .res_data    (res_data),
      .pn          (pn)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      pn.pn_out_valid = 1'b0;
      pn.pn_out = '0;
      #12;
      check_cnt++;
      if ({busy, done, err_len, err_timeout, res_cnt, res_data, pn.pn_in_valid, pn.pn_mode, pn.pn_operator, pn.pn_in} !== '0)
         $display("[TB] FAIL reset_outputs got busy=%b done=%b res_cnt=%0d valid=%b exp all zero", busy, done, res_cnt, pn.pn_in_valid);
      else pass_cnt++;
      rst_n = 1'b1;
      step();
      check_cnt++;
      if ({busy, done} !== 2'b00) $display("[TB] FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done);
      else pass_cnt++;
   endtask

   task automatic test_mode3_stack();
      logic [2:0] tv[5] = '{3'd3, 3'd4, 3'd0, 3'd2, 3'd2};
      logic [4:0] opb = 5'b10100;
      cfg_mode = 2'd3; cfg_len = 4'd5; cfg_op = {7'd0, opb}; cfg_val = '0;
      for (int k = 0; k < 5; k++) cfg_val[3*k +: 3] = tv[k];
      start = 1'b1; step(); start = 1'b0;
      check_cnt++;
      if (busy !== 1'b1) $display("[TB] FAIL m3_busy got %b exp 1", busy); else pass_cnt++;
      step();
      check_cnt++;
      if (pn.pn_in_valid !== 1'b0) $display("[TB] FAIL m3_check_novalid got %b exp 0", pn.pn_in_valid); else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         step();
         check_cnt++;
         if ({pn.pn_in_valid, pn.pn_mode, pn.pn_operator, pn.pn_in} !== {1'b1, (k == 0) ? 2'd3 : 2'd0, opb[k], tv[k]})
            $display("[TB] FAIL m3_token%0d got %b exp %b", k, {pn.pn_in_valid, pn.pn_mode, pn.pn_operator, pn.pn_in},
                     {1'b1, (k == 0) ? 2'd3 : 2'd0, opb[k], tv[k]});
         else pass_cnt++;
      end
      step();
      check_cnt++;
      if ({pn.pn_in_valid, pn.pn_mode, pn.pn_operator, pn.pn_in} !== 7'd0)
         $display("[TB] FAIL m3_after_last got %b exp 0", {pn.pn_in_valid, pn.pn_mode, pn.pn_operator, pn.pn_in});
      else pass_cnt++;
      step();
      pn.pn_out_valid = 1'b1; pn.pn_out = 32'sd14;
      step();
      pn.pn_out_valid = 1'b0;
      check_cnt++;
      if ({res_cnt, done} !== {3'd1, 1'b0}) $display("[TB] FAIL m3_capture got cnt=%0d done=%b exp 1 0", res_cnt, done);
      else pass_cnt++;
      step();
      check_cnt++;
      if ({done, busy, err_len, err_timeout, res_data[31:0]} !== {4'b1000, 32'd14})
         $display("[TB] FAIL m3_done got done=%b busy=%b el=%b et=%b r0=%0d exp 1 0 0 0 14", done, busy, err_len, err_timeout, res_data[31:0]);
      else pass_cnt++;
      step();
      check_cnt++;
      if (done !== 1'b0) $display("[TB] FAIL m3_done_pulse got %b exp 0", done); else pass_cnt++;
   endtask

   task automatic test_mode0_sorted();
      logic [2:0] tv[6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
      logic [5:0] opb = 6'b001001;
      cfg_mode = 2'd0; cfg_len = 4'd6; cfg_op = {6'd0, opb}; cfg_val = '0;
      for (int k = 0; k < 6; k++) cfg_val[3*k +: 3] = tv[k];
      start = 1'b1; step(); start = 1'b0;
      step();
      for (int k = 0; k < 6; k++) begin
         step();
         check_cnt++;
         if ({pn.pn_in_valid, pn.pn_mode, pn.pn_operator, pn.pn_in} !== {1'b1, 2'd0, opb[k], tv[k]})
            $display("[TB] FAIL m0_token%0d got %b exp %b", k, {pn.pn_in_valid, pn.pn_mode, pn.pn_operator, pn.pn_in},
                     {1'b1, 2'd0, opb[k], tv[k]});
         else pass_cnt++;
      end
      step();
      check_cnt++;
      if (pn.pn_in_valid !== 1'b0) $display("[TB] FAIL m0_seventh_strobe got %b exp 0", pn.pn_in_valid); else pass_cnt++;
      step();
      pn.pn_out_valid = 1'b1; pn.pn_out = 32'sd9;
      step();
      pn.pn_out_valid = 1'b0;
      check_cnt++;
      if (res_cnt !== 3'd1) $display("[TB] FAIL m0_first_capture got %0d exp 1", res_cnt); else pass_cnt++;
      step();
      step();
      pn.pn_out_valid = 1'b1; pn.pn_out = 32'sd3;
      step();
      pn.pn_out_valid = 1'b0;
      check_cnt++;
      if ({res_cnt, done} !== {3'd2, 1'b0}) $display("[TB] FAIL m0_second_capture got cnt=%0d done=%b exp 2 0", res_cnt, done);
      else pass_cnt++;
      step();
      check_cnt++;
      if ({done, res_data[63:32], res_data[31:0]} !== {1'b1, 32'd3, 32'd9})
         $display("[TB] FAIL m0_done got done=%b r1=%0d r0=%0d exp 1 3 9", done, res_data[63:32], res_data[31:0]);
      else pass_cnt++;
      step();
   endtask

   task automatic test_len_error();
      cfg_mode = 2'd1; cfg_len = 4'd4; cfg_op = '0; cfg_val = 36'h123;
      start = 1'b1; step(); start = 1'b0;
      check_cnt++;
      if ({busy, done} !== 2'b10) $display("[TB] FAIL lenerr_t0 got busy=%b done=%b exp 1 0", busy, done); else pass_cnt++;
      step();
      check_cnt++;
      if ({done, busy, err_len, pn.pn_in_valid} !== 4'b1010)
         $display("[TB] FAIL lenerr_done got done=%b busy=%b err_len=%b valid=%b exp 1 0 1 0", done, busy, err_len, pn.pn_in_valid);
      else pass_cnt++;
      step();
      check_cnt++;
      if ({done, pn.pn_in_valid, res_cnt, err_len} !== {2'b00, 3'd0, 1'b1})
         $display("[TB] FAIL lenerr_after got done=%b valid=%b cnt=%0d err_len=%b exp 0 0 0 1", done, pn.pn_in_valid, res_cnt, err_len);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int n;
      cfg_mode = 2'd2; cfg_len = 4'd3; cfg_op = 12'b100; cfg_val = {27'd0, 3'd0, 3'd2, 3'd1};
      start = 1'b1; step(); start = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         step();
         n++;
      end
      check_cnt++;
      if (n !== 69) $display("[TB] FAIL timeout_cycle got %0d exp 69", n); else pass_cnt++;
      check_cnt++;
      if ({err_timeout, err_len, busy, res_cnt} !== {3'b100, 3'd0})
         $display("[TB] FAIL timeout_flags got et=%b el=%b busy=%b cnt=%0d exp 1 0 0 0", err_timeout, err_len, busy, res_cnt);
      else pass_cnt++;
      step();
      cfg_mode = 2'd2; cfg_len = 4'd0;
      start = 1'b1; step(); start = 1'b0;
      check_cnt++;
      if (err_timeout !== 1'b0) $display("[TB] FAIL timeout_clear got %b exp 0", err_timeout); else pass_cnt++;
      step();
      check_cnt++;
      if ({err_len, done} !== 2'b11) $display("[TB] FAIL len0_err got el=%b done=%b exp 1 1", err_len, done); else pass_cnt++;
      step();
   endtask

   task automatic test_reset_mid_send();
      cfg_mode = 2'd3; cfg_len = 4'd5; cfg_op = 12'b10100;
      cfg_val = {21'd0, 3'd2, 3'd2, 3'd0, 3'd4, 3'd3};
      start = 1'b1; step(); start = 1'b0;
      step(); step(); step(); step();
      check_cnt++;
      if ({pn.pn_in_valid, pn.pn_operator, pn.pn_in} !== 5'b11000)
         $display("[TB] FAIL rst_token2 got %b exp 11000", {pn.pn_in_valid, pn.pn_operator, pn.pn_in});
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      check_cnt++;
      if ({busy, done, err_len, err_timeout, res_cnt, pn.pn_in_valid, pn.pn_mode, pn.pn_operator, pn.pn_in} !== '0)
         $display("[TB] FAIL rst_mid_outputs got busy=%b valid=%b in=%0d exp 0 0 0", busy, pn.pn_in_valid, pn.pn_in);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      cfg_mode = 2'd3; cfg_len = 4'd1; cfg_op = '0; cfg_val = 36'd5;
      start = 1'b1; step(); start = 1'b0;
      step();
      step();
      check_cnt++;
      if ({pn.pn_in_valid, pn.pn_mode, pn.pn_operator, pn.pn_in} !== {1'b1, 2'd3, 1'b0, 3'd5})
         $display("[TB] FAIL rst_single_token got %b exp %b", {pn.pn_in_valid, pn.pn_mode, pn.pn_operator, pn.pn_in}, {1'b1, 2'd3, 1'b0, 3'd5});
      else pass_cnt++;
      step();
      check_cnt++;
      if (pn.pn_in_valid !== 1'b0) $display("[TB] FAIL rst_single_end got %b exp 0", pn.pn_in_valid); else pass_cnt++;
      pn.pn_out_valid = 1'b1; pn.pn_out = 32'sd5;
      step();
      pn.pn_out_valid = 1'b0;
      step();
      check_cnt++;
      if ({done, res_cnt, res_data[31:0]} !== {1'b1, 3'd1, 32'd5})
         $display("[TB] FAIL rst_single_result got done=%b cnt=%0d r0=%0d exp 1 1 5", done, res_cnt, res_data[31:0]);
      else pass_cnt++;
      step();
   endtask

   task automatic test_back_to_back();
      cfg_mode = 2'd3; cfg_len = 4'd1; cfg_op = '0; cfg_val = 36'd5;
      start = 1'b1;
      step(); step(); step(); step();
      pn.pn_out_valid = 1'b1; pn.pn_out = 32'sd7;
      step();
      pn.pn_out_valid = 1'b0;
      step();
      check_cnt++;
      if ({done, busy, res_data[31:0]} !== {2'b10, 32'd7})
         $display("[TB] FAIL b2b_fin got done=%b busy=%b r0=%0d exp 1 0 7", done, busy, res_data[31:0]);
      else pass_cnt++;
      pn.pn_out_valid = 1'b1; pn.pn_out = 32'sd99;
      step();
      check_cnt++;
      if ({busy, done, res_cnt, res_data[31:0]} !== {2'b00, 3'd1, 32'd7})
         $display("[TB] FAIL b2b_idle got busy=%b done=%b cnt=%0d r0=%0d exp 0 0 1 7", busy, done, res_cnt, res_data[31:0]);
      else pass_cnt++;
      step();
      start = 1'b0;
      check_cnt++;
      if ({busy, res_cnt} !== {1'b1, 3'd0}) $display("[TB] FAIL b2b_restart got busy=%b cnt=%0d exp 1 0", busy, res_cnt);
      else pass_cnt++;
      step(); step(); step();
      check_cnt++;
      if (res_cnt !== 3'd0) $display("[TB] FAIL b2b_stray_ignored got %0d exp 0", res_cnt); else pass_cnt++;
      pn.pn_out = 32'sd5;
      step();
      pn.pn_out_valid = 1'b0;
      check_cnt++;
      if ({res_cnt, res_data[31:0]} !== {3'd1, 32'd5})
         $display("[TB] FAIL b2b_capture got cnt=%0d r0=%0d exp 1 5", res_cnt, res_data[31:0]);
      else pass_cnt++;
      step();
      check_cnt++;
      if (done !== 1'b1) $display("[TB] FAIL b2b_done got %b exp 1", done); else pass_cnt++;
      step();
   endtask

   initial begin
      test_reset();
      test_mode3_stack();
      test_mode0_sorted();
      test_len_error();
      test_timeout();
      test_reset_mid_send();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before bench completed");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/pn_token_tx.md
Name: pn_token_tx

Overview:
Transmitter end of the Polish Notation token interface. It accepts a host-loaded expression of up to 12 tokens and streams it one token per cycle to the PN evaluator using the evaluator's mode/operator/in/in_valid protocol. It then collects the evaluator's out_valid/out result burst into a result buffer and reports completion, length errors and timeouts. It sits between the test/host controller and the PN evaluator.

Parameters:
MAX_TOK, 12, maximum tokens per expression (fixed by protocol; cfg_len range 1..12)
TIMEOUT, 64, cycles allowed in WAIT between consecutive results (and before the first) before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  host request; sampled only in IDLE
cfg_mode  in  2  0 prefix-sorted-desc, 1 postfix-sorted-asc, 2 prefix-stack, 3 postfix-stack
cfg_len  in  4  token count
cfg_op  in  12  bit i = 1: token i is operator
cfg_val  in  36  token i value in bits [3i+2:3i]; operator codes 0 add, 1 sub, 2 mul, 3 abs(sum)
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
err_len  out  1  sticky until next accepted start: illegal length
err_timeout  out  1  sticky until next accepted start: result timeout
res_cnt  out  3  results captured (0..4)
res_data  out  128  result r in bits [32r+31:32r], signed
pn_mode  out  2  mode, valid on first token cycle only
pn_operator  out  1  operator flag of current token
pn_in  out  3  current token value
pn_in_valid  out  1  token strobe
pn_out_valid  in  1  evaluator result strobe
pn_out  in  32  evaluator result, signed

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; result buffer, counters and latched config 0. Reset mid-stream drops pn_in_valid immediately; no partial burst resumes.
- All outputs registered.
- States: IDLE, CHECK, SEND, WAIT, FIN.
- IDLE: if start=1, latch cfg_*, clear err_len/err_timeout/res_cnt/res_data, set busy, go CHECK. If start=0, stay in IDLE. start while busy is ignored.
- CHECK (1 cycle): expected result count exp = cfg_len/3 for modes 0/1, and 1 for modes 2/3.
  - Length is illegal if cfg_len=0, cfg_len>12, or (mode 0/1 and cfg_len not a multiple of 3).
  - Illegal length: set err_len, go FIN, send no tokens.
  - Legal length: go SEND.
- SEND: token k (k=0..len-1) is driven on consecutive cycles with pn_in_valid=1 and no gaps.
  - pn_mode = latched mode when k=0, else 0.
  - pn_operator = cfg_op[k]; pn_in = cfg_val[3k+2:3k].
  - Cycle after the last token: pn_in_valid, pn_operator, pn_in and pn_mode return to 0; go WAIT.
  - Token content is not checked (malformed expressions are forwarded as-is).
- Timing: start sampled at edge T0; CHECK at T1; first token visible after T2; token k visible after T2+k; WAIT entered len cycles after T2.
- WAIT:
  - Each cycle with pn_out_valid=1 and res_cnt<exp: write pn_out to slot res_cnt, increment res_cnt, reset the timeout counter.
  - When res_cnt reaches exp: go FIN on the next edge.
  - The timeout counter increments on every cycle without a capture. On reaching TIMEOUT: set err_timeout and go FIN; res_cnt keeps the partial count.
  - pn_out_valid in IDLE, CHECK or SEND, or beyond exp, is ignored.
- FIN (1 cycle): done=1 and busy=0 on the same cycle; go IDLE. res_data/res_cnt hold until the next accepted start.
- A start asserted on the FIN cycle is ignored. It is accepted on the following IDLE cycle.
- Result arithmetic: 32-bit signed storage as received, no modification.

Test Plan:
- Mode 3, len 5, tokens 3,4,op0,2,op2 (cfg_op=0b10100) -> pn_mode=3 on first strobe only, five contiguous strobes; evaluator model returns 14 -> res_cnt=1, res_data[31:0]=14, done one pulse, no errors.
- Mode 0, len 6, tokens op0,1,2,op2,3,3 -> exactly 6 contiguous strobes; inject results 9 and 3 on non-adjacent cycles -> res_cnt=2, slots 9,3, done after second capture.
- Mode 1, len 4 -> err_len=1, pn_in_valid never asserted, done pulses 2 cycles after start, res_cnt=0.
- Mode 2, len 3, evaluator never answers -> err_timeout=1 after 64 idle WAIT cycles, done pulse, res_cnt=0; next start clears err_timeout.
- Reset asserted during SEND token 2 -> all outputs 0 immediately; after release, start with mode 3 len 1 (token 5) -> single strobe, result 5 captured.
- start held high through FIN plus an extra result pulse in IDLE -> second transaction starts only from IDLE; the stray result is not captured.
